interrupt_controller: RTL

- Sits directly upstream of the PC selection logic and drives its `interupt` input.
- Detects rising edges on external interrupt request lines, arbitrates between pending sources, and issues a one-cycle interrupt pulse when the pipeline can accept it.
- Captures the return PC (`epc`) and source ID (`cause`), then blocks further interrupts until the handler executes a return-from-interrupt.

---
 rtl/interrupt_controller_pkg.sv | 18 +
 rtl/irq_edge_detect.sv | 30 +++
 rtl/interrupt_controller.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_pkg.sv
// Purpose: shared types and constants for the interrupt controller and the PC selection logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package interrupt_controller_pkg;

    // Controller sequencing: wait for a request, issue the pulse, run the handler.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_ISR  = 2'd2
    } ic_state_e;

    // Fixed handler entry address; the PC mux loads this when interupt is high.
    localparam int IRQ_VECTOR = 9;

    localparam int DEFAULT_NUM_SOURCES = 4;

endpackage

// File: rtl/irq_edge_detect.sv
// Purpose: registers the request lines and flags 0->1 transitions.
// Latency: rise_o is combinational from irq_i in the same cycle; history is one register stage.
// Backpressure: none; every cycle is sampled.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   irq_i       - request lines, already synchronous to clk
//   rise_o      - one bit per line, high in the cycle the line goes 0->1
module irq_edge_detect #(
    parameter int NUM_SOURCES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq_i,
    output logic [NUM_SOURCES-1:0] rise_o
);

    logic [NUM_SOURCES-1:0] irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_i;
        end
    end

    assign rise_o = irq_i & ~irq_q;

endmodule

// File: rtl/interrupt_controller.sv
// Purpose: edge-triggered interrupt capture, fixed-priority arbitration, one-cycle take pulse, EPC/cause capture.
// Latency: irq edge in cycle N -> interupt high in N+2 -> epc/cause/in_isr valid from N+3.
// Backpressure: stall holds the request pending in IDLE; no new take until reti leaves the handler.
//
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   irq                  - request lines (rising-edge triggered)
//   mask_we, mask_wdata  - per-source enable mask write (1 = enabled), effective next cycle
//   gie_set, gie_clr     - EI / DI retired; clear wins when both are high
//   reti                 - return-from-interrupt retired
//   stall                - pipeline stall shared with the PC selection logic
//   squash_pc            - PC of the oldest in-flight instruction
//   interupt             - one-cycle pulse redirecting the PC to the vector
//   epc, cause, in_isr   - saved return PC, serviced source index, handler-active flag
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
    parameter int CAUSE_W     = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
    parameter int PC_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SOURCES-1:0] irq,
    input  logic                   mask_we,
    input  logic [NUM_SOURCES-1:0] mask_wdata,
    input  logic                   gie_set,
    input  logic                   gie_clr,
    input  logic                   reti,
    input  logic                   stall,
    input  logic [PC_W-1:0]        squash_pc,
    output logic                   interupt,
    output logic [PC_W-1:0]        epc,
    output logic [CAUSE_W-1:0]     cause,
    output logic                   in_isr
);

    logic [NUM_SOURCES-1:0] rise;
    logic [NUM_SOURCES-1:0] pending_q, pending_d;
    logic [NUM_SOURCES-1:0] mask_q, mask_d;
    logic                   gie_q, gie_d;
    logic [NUM_SOURCES-1:0] eligible;
    logic [NUM_SOURCES-1:0] win_oh;
    logic [CAUSE_W-1:0]     win_idx;
    logic                   take;

    ic_state_e              state_q;
    logic                   interupt_q;
    logic [PC_W-1:0]        epc_q;
    logic [CAUSE_W-1:0]     cause_q;
    logic                   in_isr_q;

    irq_edge_detect #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_edge (
        .clk    (clk),
        .reset  (reset),
        .irq_i  (irq),
        .rise_o (rise)
    );

    // Arbitration uses the registered mask, so a same-cycle mask write only
    // affects the following cycle's decision.
    assign eligible = pending_q & mask_q;

    // Fixed priority, lowest index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        win_idx = '0;
        win_oh  = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx   = CAUSE_W'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    assign take = (state_q == ST_IDLE) && gie_q && (|eligible) && !stall;

    // Clear the serviced bit first, then OR in new edges so a fresh edge on the
    // winner in the same cycle is not lost. Edges on already-pending bits merge.
    always_comb begin
        pending_d = (pending_q & ~(take ? win_oh : '0)) | rise;
        mask_d    = mask_we ? mask_wdata : mask_q;
        gie_d     = gie_q;
        if (gie_set) gie_d = 1'b1;
        if (gie_clr) gie_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            mask_q    <= '1;
            gie_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
        end
    end

    // Sequencer with registered outputs. epc is captured while the pulse is
    // high, i.e. the WB-stage PC of the instruction the pulse squashes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            interupt_q <= 1'b0;
            epc_q      <= '0;
            cause_q    <= '0;
            in_isr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        state_q    <= ST_TAKE;
                        interupt_q <= 1'b1;
                        cause_q    <= win_idx;
                    end
                end
                ST_TAKE: begin
                    state_q    <= ST_ISR;
                    interupt_q <= 1'b0;
                    epc_q      <= squash_pc;
                    in_isr_q   <= 1'b1;
                end
                ST_ISR: begin
                    if (reti) begin
                        state_q  <= ST_IDLE;
                        in_isr_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    interupt_q <= 1'b0;
                    in_isr_q   <= 1'b0;
                end
            endcase
        end
    end

    assign interupt = interupt_q;
    assign epc      = epc_q;
    assign cause    = cause_q;
    assign in_isr   = in_isr_q;

endmodule
